// File: rtl/mmio_bank_pkg.sv
// Shared types and helpers for the MMIO register bank: access sizes, region
// decode tags and byte-lane helpers.
package mmio_bank_pkg;

  typedef enum logic [1:0] {
    DB = 2'd0,
    DH = 2'd1,
    DW = 2'd2
  } data_width;

  localparam int unsigned MMIO_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    REG_IN,
    REG_OUT,
    REG_STAT,
    REG_IE,
    REG_NONE
  } mmio_region_e;

  function automatic logic [31:0] mask(input data_width dw);
    case (dw)
      DB:      return 32'h0000_00FF;
      DH:      return 32'h0000_FFFF;
      DW:      return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Byte enables for an access; only meaningful for aligned accesses.
  function automatic logic [MMIO_WORD_BYTES-1:0] lane_strobe(input data_width dw,
                                                             input logic [1:0] off);
    case (dw)
      DB:      return 4'b0001 << off;
      DH:      return 4'b0011 << off;
      DW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mmio_bank_sampler.sv
// Two-flop capture of the peripheral inputs with per-word change detect
// between the two stages.
module mmio_sampler #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*32-1:0] d_i,
  output logic [N*32-1:0] q_o,
  output logic [N-1:0]    chg_o
);

  logic [N*32-1:0] q_q;
  logic [N*32-1:0] qq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      qq_q <= '0;
    end else begin
      q_q  <= d_i;
      qq_q <= q_q;
    end
  end

  always_comb begin
    chg_o = '0;
    for (int i = 0; i < N; i++) begin
      chg_o[i] = (q_q[i*32 +: 32] != qq_q[i*32 +: 32]);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mmio_bank.sv
// MMIO register bank: sampled inputs, read/write outputs, change STATUS with
// W1C and an interrupt enable; every request is answered exactly one cycle later.
module mmio_bank
  import mmio_bank_pkg::*;
#(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned OUT_BASE  = 16,
  parameter int unsigned STAT_W    = 32,
  parameter int unsigned IE_W      = 33,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  data_width           dw,
  input  logic [31:0]         wdata,
  output logic                ack,
  output logic [31:0]         rdata,
  output logic                err,
  input  logic [N_IN*32-1:0]  io_in,
  output logic [N_OUT*32-1:0] io_out,
  output logic [N_OUT-1:0]    io_wr_stb,
  output logic                irq
);

  logic [N_IN*32-1:0] in_flat;
  logic [N_IN-1:0]    chg;

  mmio_sampler #(.N(N_IN)) u_sampler (
    .clk   (clk),
    .rst   (rst),
    .d_i   (io_in),
    .q_o   (in_flat),
    .chg_o (chg)
  );

  logic [31:0]     out_q [N_OUT];
  logic [31:0]     out_d [N_OUT];
  logic [N_OUT-1:0] stb_q, stb_d;
  logic [N_IN-1:0] status_q, status_d;
  logic [N_IN-1:0] ie_q, ie_d;
  logic            ack_q, err_q, irq_q;
  logic [31:0]     rdata_q, rdata_d;

  logic [ADDR_W-3:0] word;
  logic [1:0]        off;
  logic [31:0]       widx;
  mmio_region_e      region;
  logic              fault;
  logic              wr_ok;
  logic [3:0]        be;
  logic [31:0]       bmask, wsh, wm, sel, merged;
  logic [N_IN-1:0]   clr;

  assign word = addr[ADDR_W-1:2];
  assign off  = addr[1:0];
  assign widx = 32'(word);

  // Region decode and current value of the addressed register.
  always_comb begin
    region = REG_NONE;
    sel    = '0;
    if (widx < N_IN) begin
      region = REG_IN;
      for (int i = 0; i < N_IN; i++) begin
        if (widx == 32'(i)) sel = in_flat[i*32 +: 32];
      end
    end else if (widx >= OUT_BASE && widx < OUT_BASE + N_OUT) begin
      region = REG_OUT;
      for (int k = 0; k < N_OUT; k++) begin
        if (widx == 32'(OUT_BASE + k)) sel = out_q[k];
      end
    end else if (widx == STAT_W) begin
      region = REG_STAT;
      sel    = 32'(status_q);
    end else if (widx == IE_W) begin
      region = REG_IE;
      sel    = 32'(ie_q);
    end
  end

  always_comb begin
    fault = (region == REG_NONE)
         || !(dw inside {DB, DH, DW})
         || (dw == DH && off[0])
         || (dw == DW && off != 2'b00)
         || (we && region == REG_IN);
    wr_ok = req && we && !fault;
    be    = lane_strobe(dw, off);
    bmask = '0;
    for (int b = 0; b < 4; b++) bmask[b*8 +: 8] = {8{be[b]}};
    wsh    = wdata << {off, 3'b000};
    wm     = wsh & bmask;
    merged = (sel & ~bmask) | wm;
    rdata_d = (req && !we && !fault) ? ((sel >> {off, 3'b000}) & mask(dw)) : '0;
  end

  always_comb begin
    out_d = out_q;
    stb_d = '0;
    ie_d  = ie_q;
    clr   = '0;
    if (wr_ok) begin
      case (region)
        REG_OUT: begin
          for (int k = 0; k < N_OUT; k++) begin
            if (widx == 32'(OUT_BASE + k)) begin
              out_d[k] = merged;
              stb_d[k] = 1'b1;
            end
          end
        end
        REG_IE:   ie_d = merged[N_IN-1:0];
        REG_STAT: clr  = wm[N_IN-1:0];
        default: ;
      endcase
    end
    // A new change in the same cycle as a clear keeps the bit set.
    status_d = (status_q & ~clr) | chg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      stb_q    <= '0;
      status_q <= '0;
      ie_q     <= '0;
      irq_q    <= 1'b0;
      for (int k = 0; k < N_OUT; k++) out_q[k] <= OUT_RESET;
    end else begin
      ack_q    <= req;
      err_q    <= req && fault;
      rdata_q  <= rdata_d;
      stb_q    <= stb_d;
      status_q <= status_d;
      ie_q     <= ie_d;
      irq_q    <= |(status_q & ie_q);
      out_q    <= out_d;
    end
  end

  always_comb begin
    io_out = '0;
    for (int k = 0; k < N_OUT; k++) io_out[k*32 +: 32] = out_q[k];
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign io_wr_stb = stb_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_bank.sv
// Directed plus randomized checks of mmio_bank against a byte-level
// behavioural model of the register window.
module tb_mmio_bank;
  import mmio_bank_pkg::*;

  localparam int N_IN     = 4;
  localparam int N_OUT    = 4;
  localparam int OUT_BASE = 16;
  localparam int STAT_W   = 32;
  localparam int IE_W     = 33;
  localparam logic [31:0] OUT_RESET = 32'h0;

  logic                clk = 1'b0;
  logic                rst, req, we;
  logic [7:0]          addr;
  data_width           dw;
  logic [31:0]         wdata;
  logic                ack, err, irq;
  logic [31:0]         rdata;
  logic [N_IN*32-1:0]  io_in;
  logic [N_OUT*32-1:0] io_out;
  logic [N_OUT-1:0]    io_wr_stb;

  mmio_bank dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .dw(dw),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .io_in(io_in),
    .io_out(io_out), .io_wr_stb(io_wr_stb), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ack_seen = 0;

  // Reference state
  logic [31:0] out_m [N_OUT];
  logic [31:0] inq_m [N_IN];
  logic [31:0] inqq_m [N_IN];
  logic [31:0] stat_m, ie_m;
  logic        e_ack, e_err, e_irq;
  logic [31:0] e_rdata;
  logic [N_OUT-1:0] e_stb;
  localparam logic [31:0] NMASK = (32'h1 << N_IN) - 32'h1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input data_width d);
    case (d)
      DB:      return 1;
      DH:      return 2;
      DW:      return 4;
      default: return 0;
    endcase
  endfunction

  // 0 in, 1 out, 2 status, 3 ie, 4 unmapped
  function automatic int region_of(input int w);
    if (w < N_IN) return 0;
    if (w >= OUT_BASE && w < OUT_BASE + N_OUT) return 1;
    if (w == STAT_W) return 2;
    if (w == IE_W) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] rd_bytes(input logic [31:0] v, input int off, input int sz);
    logic [31:0] r = '0;
    for (int b = 0; b < sz; b++) r[8*b +: 8] = v[8*(off+b) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] wr_bytes(input logic [31:0] v, input int off, input int sz,
                                           input logic [31:0] wd);
    logic [31:0] r = v;
    for (int b = 0; b < sz; b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] pack_out();
    logic [127:0] p = '0;
    for (int k = 0; k < N_OUT; k++) p[32*k +: 32] = out_m[k];
    return p;
  endfunction

  // Advance one clock: predict from the inputs presented now, then compare.
  task automatic cycle();
    int w, off, sz, rg;
    bit flt;
    logic [31:0] cur, chg;
    if (rst) begin
      e_ack = 0; e_err = 0; e_rdata = '0; e_stb = '0; e_irq = 0;
      stat_m = '0; ie_m = '0;
      for (int k = 0; k < N_OUT; k++) out_m[k] = OUT_RESET;
      for (int i = 0; i < N_IN; i++) begin inq_m[i] = '0; inqq_m[i] = '0; end
    end else begin
      e_ack = req; e_err = 0; e_rdata = '0; e_stb = '0;
      e_irq = |(stat_m & ie_m);
      chg = '0;
      for (int i = 0; i < N_IN; i++) chg[i] = (inq_m[i] != inqq_m[i]);
      if (req) begin
        w = int'(addr) / 4; off = int'(addr) % 4; sz = size_of(dw);
        rg = region_of(w);
        flt = (rg == 4) || (sz == 0) || (we && rg == 0);
        if (!flt && (off % sz) != 0) flt = 1;
        case (rg)
          0: cur = inq_m[w];
          1: cur = out_m[w - OUT_BASE];
          2: cur = stat_m;
          3: cur = ie_m;
          default: cur = '0;
        endcase
        if (flt) e_err = 1;
        else if (!we) e_rdata = rd_bytes(cur, off, sz);
        else begin
          case (rg)
            1: begin out_m[w - OUT_BASE] = wr_bytes(cur, off, sz, wdata); e_stb[w - OUT_BASE] = 1; end
            2: stat_m = stat_m & ~wr_bytes(32'h0, off, sz, wdata);
            3: ie_m = wr_bytes(cur, off, sz, wdata) & NMASK;
            default: ;
          endcase
        end
      end
      stat_m = stat_m | chg;
      for (int i = 0; i < N_IN; i++) begin
        inqq_m[i] = inq_m[i];
        inq_m[i]  = io_in[32*i +: 32];
      end
    end
    @(posedge clk);
    #1;
    chk("ack", 128'(ack), 128'(e_ack));
    chk("rdata", 128'(rdata), 128'(e_rdata));
    chk("err", 128'(err), 128'(e_err));
    chk("irq", 128'(irq), 128'(e_irq));
    chk("io_out", 128'(io_out), pack_out());
    chk("io_wr_stb", 128'(io_wr_stb), 128'(e_stb));
    if (ack === 1'b1) ack_seen++;
  endtask

  task automatic acc(input bit w, input logic [7:0] a, input data_width d, input logic [31:0] wd);
    req = 1; we = w; addr = a; dw = d; wdata = wd;
    cycle();
    req = 0; we = 0;
  endtask

  initial begin
    int wsel, widx, offr, dsel;
    rst = 1; req = 0; we = 0; addr = '0; dw = DW; wdata = '0; io_in = '0;
    cycle(); cycle();
    rst = 0;

    // Reset state and first read
    acc(0, 8'h40, DW, 0);
    chk("rst_read_rdata", 128'(rdata), 128'h0);
    chk("rst_read_err", 128'(err), 128'h0);
    chk("rst_irq", 128'(irq), 128'h0);

    // Word write then byte merge
    acc(1, 8'h40, DW, 32'hA5A5_1234);
    chk("stb_word", 128'(io_wr_stb[0]), 128'h1);
    acc(1, 8'h42, DB, 32'h0000_00FF);
    chk("stb_byte", 128'(io_wr_stb[0]), 128'h1);
    chk("out0_merge", 128'(io_out[31:0]), 128'hA5FF_1234);
    acc(0, 8'h42, DH, 0);
    chk("dh_read", 128'(rdata), 128'h0000_A5FF);

    // Change detect, interrupt, W1C
    acc(1, 8'h84, DW, 32'h2);
    io_in[63:32] = 32'hDEAD_BEEF;
    cycle(); cycle();
    chk("irq_not_yet", 128'(irq), 128'h0);
    cycle();
    chk("irq_set", 128'(irq), 128'h1);
    acc(1, 8'h80, DW, 32'h2);
    cycle();
    chk("irq_clear", 128'(irq), 128'h0);

    // Faults
    acc(0, 8'h42, DW, 0);
    chk("err_dw_mis", 128'({err, rdata}), 128'({1'b1, 32'h0}));
    acc(0, 8'h41, DH, 0);
    chk("err_dh_mis", 128'({err, rdata}), 128'({1'b1, 32'h0}));
    acc(1, 8'h00, DW, 32'hFFFF_FFFF);
    chk("err_wr_in", 128'(err), 128'h1);
    acc(0, 8'hA0, DW, 0);
    chk("err_unmapped", 128'({err, rdata}), 128'({1'b1, 32'h0}));
    acc(1, 8'h40, data_width'(2'd3), 32'h1111_1111);
    chk("err_bad_dw", 128'(err), 128'h1);
    chk("err_no_change", 128'(io_out[31:0]), 128'hA5FF_1234);

    // Set-beats-clear collision on STATUS[0]
    io_in[31:0] = 32'h1;
    cycle(); cycle();
    io_in[31:0] = 32'h0;
    cycle();
    acc(1, 8'h80, DB, 32'h1);
    acc(0, 8'h80, DW, 0);
    chk("collision_stat", 128'(rdata), 128'h1);

    // Back-to-back on OUT1, reset during the last request
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      req = 1; we = (i % 2 == 0); addr = 8'h44; dw = DW; wdata = $urandom;
      rst = (i == 7);
      cycle();
    end
    req = 0; we = 0; rst = 0;
    cycle();
    chk("b2b_acks", 128'(ack_seen), 128'd7);
    chk("b2b_no_ack", 128'(ack), 128'h0);
    chk("b2b_out1_reset", 128'(io_out[63:32]), 128'(OUT_RESET));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      req = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1);
      wsel = $urandom_range(0, 5);
      case (wsel)
        0:       widx = $urandom_range(0, N_IN - 1);
        1, 2:    widx = OUT_BASE + $urandom_range(0, N_OUT - 1);
        3:       widx = STAT_W;
        4:       widx = IE_W;
        default: widx = $urandom_range(0, 63);
      endcase
      offr = $urandom_range(0, 3);
      addr = 8'((widx << 2) | offr);
      dsel = $urandom_range(0, 9);
      dw = (dsel < 3) ? DB : (dsel < 6) ? DH : (dsel < 9) ? DW : data_width'(2'd3);
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0)
        io_in[32*$urandom_range(0, N_IN-1) +: 32] = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0;
      cycle();
    end
    req = 0; rst = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
